hazard_stall_controller: RTL

HAZARD_STALL_CONTROLLER -- requirements
Module: hazard_stall_controller

---
 rtl/hazard_stall_controller.sv | 97 +++++++++
 1 files changed

// File: rtl/hazard_stall_controller.sv
// Pipeline hazard/stall controller: load-use and HI/LO interlocks, branch/jump flushes,
// instruction-memory wait handling and a saturating stall-cycle counter.
module hazard_stall_controller #(
   parameter int unsigned MD_CYCLES = 32
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic [4:0] id_rs,
   input  logic [4:0] id_rt,
   input  logic       id_uses_rt,
   input  logic       id_reads_hilo,
   input  logic       id_jump,
   input  logic       ex_mem_read,
   input  logic [4:0] ex_rt,
   input  logic       ex_branch_taken,
   input  logic       ex_md_start,
   input  logic       imem_ready,
   output logic       pc_write,
   output logic       if_id_stall,
   output logic       if_id_flush,
   output logic       id_ex_flush,
   output logic [15:0] stall_count
);

   localparam logic [7:0] MD_RELOAD = 8'(MD_CYCLES - 1);

   logic [7:0]  md_cnt_r;
   logic [15:0] stall_count_r;
   logic        load_use_s;
   logic        hilo_s;
   logic        id_stall_s;

   // Hazard detection from the ID/EX operand fields and the mult/div busy window
   always_comb begin
      load_use_s = ex_mem_read && (ex_rt != 5'd0) &&
                   ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));
      hilo_s     = id_reads_hilo && (ex_md_start || (md_cnt_r != 8'd0));
      id_stall_s = load_use_s || hilo_s;
   end

   // Prioritised pipeline control; reset forces a flushed, frozen front end
   always_comb begin
      pc_write    = 1'b1;
      if_id_stall = 1'b0;
      if_id_flush = 1'b0;
      id_ex_flush = 1'b0;
      if (!reset_n) begin
         pc_write    = 1'b0;
         if_id_flush = 1'b1;
         id_ex_flush = 1'b1;
      end else if (ex_branch_taken) begin
         pc_write    = 1'b1;
         if_id_flush = 1'b1;
         id_ex_flush = 1'b1;
      end else if (id_stall_s) begin
         pc_write    = 1'b0;
         if_id_stall = 1'b1;
         id_ex_flush = 1'b1;
      end else if (!imem_ready) begin
         // ID instruction moves on while a bubble is fetched into ID
         pc_write    = 1'b0;
         if_id_flush = 1'b1;
      end else if (id_jump) begin
         pc_write    = 1'b1;
         if_id_flush = 1'b1;
      end else begin
         pc_write    = 1'b1;
      end
   end

   // HI/LO busy down-counter, restarted by every mult/div issue
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         md_cnt_r <= 8'd0;
      end else if (ex_md_start) begin
         md_cnt_r <= MD_RELOAD;
      end else if (md_cnt_r != 8'd0) begin
         md_cnt_r <= md_cnt_r - 8'd1;
      end else begin
         md_cnt_r <= md_cnt_r;
      end
   end

   // Saturating count of cycles in which the PC did not advance
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         stall_count_r <= 16'd0;
      end else if (!pc_write && (stall_count_r != 16'hFFFF)) begin
         stall_count_r <= stall_count_r + 16'd1;
      end else begin
         stall_count_r <= stall_count_r;
      end
   end

   assign stall_count = stall_count_r;

endmodule
